// File: rtl/pmod_arb_pkg.sv
// Shared types and constants for the PMOD bank arbiter: FSM states,
// register map offsets and CTRL/STATUS field positions.
package pmod_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_OWNED = 2'd2
    } arb_state_t;

    // Byte offsets of the register map
    localparam logic [11:0] ADDR_CTRL    = 12'h000;
    localparam logic [11:0] ADDR_GUARD   = 12'h004;
    localparam logic [11:0] ADDR_STATUS  = 12'h008;
    localparam logic [11:0] ADDR_QUANTUM = 12'h00C;

    // Word indexes as decoded from PADDR[3:2]
    localparam logic [1:0] W_CTRL    = 2'd0;
    localparam logic [1:0] W_GUARD   = 2'd1;
    localparam logic [1:0] W_STATUS  = 2'd2;
    localparam logic [1:0] W_QUANTUM = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_MODE_BIT   = 1;
    localparam int CTRL_FO_LSB     = 2;
    localparam int CTRL_FO_MSB     = 3;
    localparam int CTRL_IRQ_EN_BIT = 4;

    localparam int STATUS_IRQ_PEND_BIT = 4;

    localparam int PAD_W = 16;

    // Field order matches the CTRL bit positions above (en is bit 0)
    typedef struct packed {
        logic       irq_en;
        logic [1:0] fixed_owner;
        logic       mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/pmod_arbiter_if.sv
// APB slave bus bundle for the PMOD arbiter register file.
interface pmod_arbiter_if;
    logic [31:0] PADDR;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PENABLE, PSEL, PWDATA, PWRITE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PENABLE, PSEL, PWDATA, PWRITE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/pmod_arb_regs.sv
// Zero-wait APB register file: CTRL, GUARD, STATUS (irq_pend W1C) and QUANTUM,
// plus the registered interrupt output.
module pmod_arb_regs
    import pmod_arb_pkg::*;
#(
    parameter int QW = 16
) (
    input  logic              clk_in,
    input  logic              reset_int,
    pmod_arbiter_if.slave     apb,
    input  logic              st_owned,
    input  logic [1:0]        st_owner,
    input  logic              st_guard,
    input  logic              owned_entry,
    output logic              cfg_en,
    output logic              cfg_mode,
    output logic [1:0]        cfg_fixed_owner,
    output logic [7:0]        guard_cfg,
    output logic [QW-1:0]     quantum_cfg,
    output logic              irq
);

    ctrl_t          ctrl_reg;
    logic [7:0]     guard_reg;
    logic [QW-1:0]  quantum_reg;
    logic           irq_pend_reg;
    logic           irq_reg;

    logic           addr_err;
    logic           access;
    logic           wr_en;
    logic [1:0]     word;
    logic [31:0]    rdata;
    logic           unused_bits;

    assign word     = apb.PADDR[3:2];
    assign addr_err = (apb.PADDR[11:4] != 8'd0);
    assign access   = apb.PSEL & apb.PENABLE;
    assign wr_en    = access & apb.PWRITE & ~addr_err;

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = access & addr_err;
    assign apb.PRDATA  = rdata;

    assign unused_bits = ^{apb.PADDR, apb.PWDATA};

    always_comb begin
        rdata = '0;
        if (!addr_err) begin
            case (word)
                W_CTRL:   rdata[4:0]    = ctrl_reg;
                W_GUARD:  rdata[7:0]    = guard_reg;
                W_STATUS: rdata[4:0]    = {irq_pend_reg, st_guard, st_owner, st_owned};
                default:  rdata[QW-1:0] = quantum_reg;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            ctrl_reg     <= '0;
            guard_reg    <= '0;
            quantum_reg  <= '0;
            irq_pend_reg <= 1'b0;
            irq_reg      <= 1'b0;
        end else begin
            if (wr_en) begin
                case (word)
                    W_CTRL:    ctrl_reg    <= ctrl_t'(apb.PWDATA[CTRL_IRQ_EN_BIT:CTRL_EN_BIT]);
                    W_GUARD:   guard_reg   <= apb.PWDATA[7:0];
                    W_QUANTUM: quantum_reg <= apb.PWDATA[QW-1:0];
                    default:   ;
                endcase
            end
            // A new ownership beats a simultaneous clear so no event is lost
            if (owned_entry)
                irq_pend_reg <= 1'b1;
            else if (wr_en && word == W_STATUS && apb.PWDATA[STATUS_IRQ_PEND_BIT])
                irq_pend_reg <= 1'b0;
            irq_reg <= irq_pend_reg & ctrl_reg.irq_en;
        end
    end

    assign cfg_en          = ctrl_reg.en;
    assign cfg_mode        = ctrl_reg.mode;
    assign cfg_fixed_owner = ctrl_reg.fixed_owner;
    assign guard_cfg       = guard_reg;
    assign quantum_cfg     = quantum_reg;
    assign irq             = irq_reg;

endmodule

// File: rtl/pmod_arbiter.sv
// Arbitrates a shared PMOD pad bank between NREQ subsystems with fixed or
// round-robin ownership, guard gaps on handover and quantum-based preemption.
module pmod_arbiter
    import pmod_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int QW   = 16
) (
    input  logic                    clk_in,
    input  logic                    reset_int,
    pmod_arbiter_if.slave           apb,
    input  logic [NREQ-1:0]         ss_req,
    input  logic [PAD_W*NREQ-1:0]   ss_gpo,
    input  logic [PAD_W*NREQ-1:0]   ss_oe,
    output logic [NREQ-1:0]         ss_grant,
    output logic [PAD_W-1:0]        pmod_gpo,
    output logic [PAD_W-1:0]        pmod_gpio_oe,
    output logic                    irq
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] REQ_ONE = NREQ'(1);

    arb_state_t      state_reg;
    logic [OW-1:0]   owner_reg;
    logic [OW-1:0]   last_owner_reg;
    logic [NREQ-1:0] grant_reg;
    logic [7:0]      guard_cnt_reg;
    logic [QW-1:0]   quant_cnt_reg;
    logic            owned_entry_reg;

    logic            cfg_en;
    logic            cfg_mode;
    logic [1:0]      cfg_fixed_owner;
    logic [7:0]      guard_cfg;
    logic [QW-1:0]   quantum_cfg;

    logic            cand_valid;
    logic [OW-1:0]   cand_idx;
    logic [OW-1:0]   scan_idx;
    logic            others_req;
    logic [QW-1:0]   quant_next;
    logic            rr_preempt;
    logic            fixed_preempt;

    logic [PAD_W-1:0] gpo_slice [NREQ];
    logic [PAD_W-1:0] oe_slice  [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign gpo_slice[gi] = ss_gpo[gi*PAD_W +: PAD_W];
        assign oe_slice[gi]  = ss_oe[gi*PAD_W +: PAD_W];
    end

    pmod_arb_regs #(.QW(QW)) u_regs (
        .clk_in          (clk_in),
        .reset_int       (reset_int),
        .apb             (apb),
        .st_owned        (state_reg == ST_OWNED),
        .st_owner        (2'(owner_reg)),
        .st_guard        (state_reg == ST_GUARD),
        .owned_entry     (owned_entry_reg),
        .cfg_en          (cfg_en),
        .cfg_mode        (cfg_mode),
        .cfg_fixed_owner (cfg_fixed_owner),
        .guard_cfg       (guard_cfg),
        .quantum_cfg     (quantum_cfg),
        .irq             (irq)
    );

    // Descending scan so the nearest requester after last_owner wins
    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = '0;
        scan_idx   = '0;
        if (cfg_mode) begin
            for (int i = NREQ; i >= 1; i--) begin
                scan_idx = OW'((int'(last_owner_reg) + i) % NREQ);
                if (ss_req[scan_idx]) begin
                    cand_valid = 1'b1;
                    cand_idx   = scan_idx;
                end
            end
        end else if (int'(cfg_fixed_owner) < NREQ) begin
            cand_idx   = OW'(cfg_fixed_owner);
            cand_valid = ss_req[cand_idx];
        end
    end

    // The quantum counter includes the current cycle, so QUANTUM=N yields N owned cycles
    assign others_req    = |(ss_req & ~(REQ_ONE << owner_reg));
    assign quant_next    = (others_req && !(&quant_cnt_reg)) ? quant_cnt_reg + QW'(1) : quant_cnt_reg;
    assign rr_preempt    = cfg_mode && (quantum_cfg != '0) && (quant_next >= quantum_cfg)
                           && cand_valid && (cand_idx != owner_reg);
    assign fixed_preempt = !cfg_mode && cand_valid && (cand_idx != owner_reg);

    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            state_reg       <= ST_IDLE;
            owner_reg       <= '0;
            last_owner_reg  <= OW'(NREQ - 1);
            grant_reg       <= '0;
            guard_cnt_reg   <= '0;
            quant_cnt_reg   <= '0;
            owned_entry_reg <= 1'b0;
        end else begin
            owned_entry_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_en && cand_valid) begin
                        owner_reg <= cand_idx;
                        if (guard_cfg == 8'd0) begin
                            state_reg       <= ST_OWNED;
                            grant_reg       <= REQ_ONE << cand_idx;
                            last_owner_reg  <= cand_idx;
                            quant_cnt_reg   <= '0;
                            owned_entry_reg <= 1'b1;
                        end else begin
                            state_reg     <= ST_GUARD;
                            guard_cnt_reg <= guard_cfg;
                        end
                    end
                end
                ST_GUARD: begin
                    if (!cfg_en || !ss_req[owner_reg]) begin
                        state_reg     <= ST_IDLE;
                        guard_cnt_reg <= '0;
                    end else if (guard_cnt_reg <= 8'd1) begin
                        state_reg       <= ST_OWNED;
                        grant_reg       <= REQ_ONE << owner_reg;
                        last_owner_reg  <= owner_reg;
                        quant_cnt_reg   <= '0;
                        guard_cnt_reg   <= '0;
                        owned_entry_reg <= 1'b1;
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg - 8'd1;
                    end
                end
                ST_OWNED: begin
                    if (!cfg_en || !ss_req[owner_reg]) begin
                        state_reg     <= ST_IDLE;
                        grant_reg     <= '0;
                        quant_cnt_reg <= '0;
                    end else if (rr_preempt || fixed_preempt) begin
                        owner_reg     <= cand_idx;
                        quant_cnt_reg <= '0;
                        // Zero guard hands the bank straight to the next owner
                        if (guard_cfg == 8'd0) begin
                            grant_reg       <= REQ_ONE << cand_idx;
                            last_owner_reg  <= cand_idx;
                            owned_entry_reg <= 1'b1;
                        end else begin
                            state_reg     <= ST_GUARD;
                            grant_reg     <= '0;
                            guard_cnt_reg <= guard_cfg;
                        end
                    end else begin
                        quant_cnt_reg <= quant_next;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= '0;
                end
            endcase
        end
    end

    assign ss_grant     = grant_reg;
    assign pmod_gpo     = (state_reg == ST_OWNED) ? gpo_slice[owner_reg] : '0;
    assign pmod_gpio_oe = (state_reg == ST_OWNED) ? oe_slice[owner_reg]  : '0;

endmodule
